// File: rtl/faller_if.sv
// ============================================================================
// Module : faller_if
// Purpose: Bundles the signals between the falling-block source (faller) and
//          its consumers (stack, VGA renderer).
// Signals:
//   pause       consumer -> faller  1   freeze movement and respawn countdown
//   collision   consumer -> faller  1   one-cycle catch pulse from stack
//   fall_x      faller -> consumer  10  block column, left edge
//   fall_y      faller -> consumer  10  block row, top edge; 1023 = parked
//   fall_color  faller -> consumer  2   block colour, never 2'b00 while active
//   active      faller -> consumer  1   a block is falling
//   miss        faller -> consumer  1   one-cycle pulse on an uncaught block
//   catches     faller -> consumer  8   saturating catch count
//   misses      faller -> consumer  4   saturating miss count
// Modports: master = faller side, slave = consumer side.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface faller_if;
  logic       pause;
  logic       collision;
  logic [9:0] fall_x;
  logic [9:0] fall_y;
  logic [1:0] fall_color;
  logic       active;
  logic       miss;
  logic [7:0] catches;
  logic [3:0] misses;

  modport master (
    input  pause, collision,
    output fall_x, fall_y, fall_color, active, miss, catches, misses
  );

  modport slave (
    output pause, collision,
    input  fall_x, fall_y, fall_color, active, miss, catches, misses
  );
endinterface

`default_nettype wire

// File: rtl/faller.sv
// ============================================================================
// Module : faller
// Purpose: Falling-block source for the stacking game. One block is live at a
//          time: it spawns at a pseudo-random column/colour, descends on each
//          movement tick, and parks off-screen (fall_y = 1023) after a catch
//          or a miss. A fixed number of ticks passes before the next spawn.
// Ports  :
//   clk   in   system clock
//   rst   in   asynchronous, active-high reset
//   bus   faller_if.master (pause/collision in; position, colour, status and
//         counters out)
// Config : SPEEDUP_EN - when defined, the fall step grows by one pixel every
//          four catches, capped at STEP+3. Undefined: constant STEP.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module faller #(
  parameter int unsigned DIV_BITS      = 18,
  parameter int unsigned SPAWN_Y       = 0,
  parameter int unsigned FLOOR_Y       = 460,
  parameter int unsigned X_MAX         = 490,
  parameter int unsigned STEP          = 1,
  parameter int unsigned RESPAWN_TICKS = 32,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic     clk,
  input  logic     rst,
  faller_if.master bus
);

  localparam int unsigned WCW = (RESPAWN_TICKS < 2) ? 1 : $clog2(RESPAWN_TICKS + 1);
  localparam logic [WCW-1:0] WAIT_RELOAD = WCW'(RESPAWN_TICKS);
  localparam logic [9:0]     PARK_Y      = 10'h3FF;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_SPAWN = 3'd1,
    S_FALL  = 3'd2,
    S_CATCH = 3'd3,
    S_MISS  = 3'd4
  } state_t;

  state_t              state_q;
  logic [DIV_BITS-1:0] div_q;
  logic [WCW-1:0]      wait_cnt_q;
  logic [15:0]         lfsr_q;
  logic [9:0]          fall_x_q;
  logic [9:0]          fall_y_q;
  logic [1:0]          fall_color_q;
  logic                active_q;
  logic                miss_q;
  logic [7:0]          catches_q;
  logic [3:0]          misses_q;

  logic [15:0] lfsr_d;
  logic [9:0]  spawn_x_d;
  logic [1:0]  spawn_color_d;
  logic [9:0]  step_d;
  logic [9:0]  fall_y_d;
  logic        tick;

  // Galois LFSR, right-shifting; runs every clock, even while paused, so the
  // spawn sequence depends on how long the player paused.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  assign tick = (div_q == '0) && !bus.pause;

  assign spawn_x_d     = ({1'b0, lfsr_q[8:0]} > 10'(X_MAX)) ? 10'(X_MAX) : {1'b0, lfsr_q[8:0]};
  // Colour 00 means "no block" to the renderer, so it is remapped to 01.
  assign spawn_color_d = (lfsr_q[15:14] == 2'b00) ? 2'b01 : lfsr_q[15:14];

`ifdef SPEEDUP_EN
  logic [5:0] boost;
  assign boost  = catches_q[7:2];
  assign step_d = 10'(STEP) + ((boost > 6'd3) ? 10'd3 : {4'b0000, boost});
`else
  assign step_d = 10'(STEP);
`endif

  // FLOOR_Y + step stays below 1023, so this 10-bit sum cannot wrap.
  assign fall_y_d = fall_y_q + step_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_WAIT;
      div_q        <= '0;
      wait_cnt_q   <= WAIT_RELOAD;
      lfsr_q       <= LFSR_SEED;
      fall_x_q     <= 10'd0;
      fall_y_q     <= PARK_Y;
      fall_color_q <= 2'b00;
      active_q     <= 1'b0;
      miss_q       <= 1'b0;
      catches_q    <= 8'd0;
      misses_q     <= 4'd0;
    end else begin
      div_q  <= div_q + 1'b1;
      lfsr_q <= lfsr_d;
      miss_q <= 1'b0;
      // Pause freezes the whole sequencer, not just the tick.
      if (!bus.pause) begin
        case (state_q)
          S_WAIT: begin
            if (tick) begin
              wait_cnt_q <= wait_cnt_q - 1'b1;
              if (wait_cnt_q == WCW'(1)) state_q <= S_SPAWN;
            end
          end
          S_SPAWN: begin
            fall_x_q     <= spawn_x_d;
            fall_color_q <= spawn_color_d;
            fall_y_q     <= 10'(SPAWN_Y);
            active_q     <= 1'b1;
            state_q      <= S_FALL;
          end
          S_FALL: begin
            // A catch beats a floor hit arriving on the same clock.
            if (bus.collision) begin
              state_q <= S_CATCH;
            end else if (tick) begin
              fall_y_q <= fall_y_d;
              if (fall_y_d >= 10'(FLOOR_Y)) state_q <= S_MISS;
            end
          end
          S_CATCH: begin
            if (catches_q != 8'hFF) catches_q <= catches_q + 1'b1;
            fall_y_q   <= PARK_Y;
            active_q   <= 1'b0;
            wait_cnt_q <= WAIT_RELOAD;
            state_q    <= S_WAIT;
          end
          S_MISS: begin
            miss_q <= 1'b1;
            if (misses_q != 4'hF) misses_q <= misses_q + 1'b1;
            fall_y_q   <= PARK_Y;
            active_q   <= 1'b0;
            wait_cnt_q <= WAIT_RELOAD;
            state_q    <= S_WAIT;
          end
          default: state_q <= S_WAIT;
        endcase
      end
    end
  end

  assign bus.fall_x     = fall_x_q;
  assign bus.fall_y     = fall_y_q;
  assign bus.fall_color = fall_color_q;
  assign bus.active     = active_q;
  assign bus.miss       = miss_q;
  assign bus.catches    = catches_q;
  assign bus.misses     = misses_q;

endmodule

`default_nettype wire
